// File: rtl/arbitro_memoria_dados.sv
// arbitro_memoria_dados: round-robin arbiter and access sequencer placed in
// front of the single-port data memory. Requester 0 is the processor
// load/store path and requester 1 is a secondary master. Each access is
// granted on its own and ends with a one-cycle completion pulse to its owner.
module arbitro_memoria_dados #(
    parameter int LARGURA          = 32,
    parameter int LATENCIA_LEITURA = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req0,
    input  logic               we0,
    input  logic [LARGURA-1:0] end0,
    input  logic [LARGURA-1:0] dado0,
    output logic               pronto0,
    output logic [LARGURA-1:0] lido0,
    input  logic               req1,
    input  logic               we1,
    input  logic [LARGURA-1:0] end1,
    input  logic [LARGURA-1:0] dado1,
    output logic               pronto1,
    output logic [LARGURA-1:0] lido1,
    output logic               memRead,
    output logic               memWrite,
    output logic [LARGURA-1:0] endereco,
    output logic [LARGURA-1:0] dadoEscrita,
    input  logic [LARGURA-1:0] dadoLido
);

    // The read counter runs from LATENCIA_LEITURA-1 down to 0, one step per cycle.
    localparam int CW = (LATENCIA_LEITURA > 1) ? $clog2(LATENCIA_LEITURA) : 1;
    localparam logic [CW-1:0] CONTA_INICIAL = CW'(LATENCIA_LEITURA - 1);

    typedef enum logic [1:0] {
        OCIOSO,
        ACESSO,
        CONCLUI
    } estado_t;

    estado_t        estado;
    logic           ultimo;      // index of the last granted requester
    logic           indice;      // owner of the access in flight
    logic           escrita;     // direction of the access in flight
    logic [CW-1:0]  conta;

    logic               concede;
    logic               concede_idx;
    logic               sel_we;
    logic [LARGURA-1:0] sel_end;
    logic [LARGURA-1:0] sel_dado;

    // Round-robin choice among pending requests and the fields of the winner
    always_comb begin
        // NOTE: every signal gets a default before the branches so no path leaves it unassigned, which would infer a latch.
        concede     = 1'b0;
        concede_idx = 1'b0;
        if (req0 && req1) begin
            concede     = 1'b1;
            concede_idx = ~ultimo;
        end else if (req0) begin
            concede     = 1'b1;
            concede_idx = 1'b0;
        end else if (req1) begin
            concede     = 1'b1;
            concede_idx = 1'b1;
        end
        sel_we   = concede_idx ? we1   : we0;
        sel_end  = concede_idx ? end1  : end0;
        sel_dado = concede_idx ? dado1 : dado0;
    end

    // Arbitration and memory sequencing FSM; every output is registered
    always_ff @(posedge clock) begin
        // NOTE: state uses non-blocking assignments so all registers update from the values present before the edge.
        if (!reset) begin
            estado      <= OCIOSO;
            ultimo      <= 1'b1;
            indice      <= 1'b0;
            escrita     <= 1'b0;
            conta       <= '0;
            memRead     <= 1'b0;
            memWrite    <= 1'b0;
            endereco    <= '0;
            dadoEscrita <= '0;
            pronto0     <= 1'b0;
            pronto1     <= 1'b0;
            lido0       <= '0;
            lido1       <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (concede) begin
                        indice      <= concede_idx;
                        ultimo      <= concede_idx;
                        escrita     <= sel_we;
                        endereco    <= sel_end;
                        dadoEscrita <= sel_we ? sel_dado : '0;
                        memWrite    <= sel_we;
                        memRead     <= ~sel_we;
                        conta       <= CONTA_INICIAL;
                        estado      <= ACESSO;
                    end
                end
                ACESSO: begin
                    // A write lasts one cycle; a read lasts until the counter expires.
                    if (escrita || conta == '0) begin
                        if (!escrita) begin
                            if (indice) lido1 <= dadoLido;
                            else        lido0 <= dadoLido;
                        end
                        memRead     <= 1'b0;
                        memWrite    <= 1'b0;
                        endereco    <= '0;
                        dadoEscrita <= '0;
                        pronto0     <= ~indice;
                        pronto1     <= indice;
                        estado      <= CONCLUI;
                    end else begin
                        conta <= conta - 1'b1;
                    end
                end
                CONCLUI: begin
                    pronto0 <= 1'b0;
                    pronto1 <= 1'b0;
                    estado  <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule
